// File: rtl/keypad_entry_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_controller_if
// Description : Keypad input, control and status bundle for the keypad entry
//               controller. The slave modport is the controller side; the
//               master modport is the keypad/host side.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_entry_controller_if;
    logic [4:0]  bcd_in;        // [4] valid, [3:0] digit
    logic        mode;          // 0 = enter code, 1 = set new code
    logic        clear;         // discard entry or relock
    logic        press_ack;     // one-cycle strobe per accepted press
    logic [15:0] entry_buf;     // digits entered so far, newest in [3:0]
    logic [2:0]  digit_count;   // digits held in entry_buf
    logic        unlocked;      // state is OPEN
    logic        error;         // one-cycle pulse on code mismatch
    logic        code_updated;  // one-cycle pulse when stored code replaced
    logic        locked_out;    // state is LOCKOUT

    modport slave (
        input  bcd_in, mode, clear,
        output press_ack, entry_buf, digit_count, unlocked, error,
               code_updated, locked_out
    );

    modport master (
        output bcd_in, mode, clear,
        input  press_ack, entry_buf, digit_count, unlocked, error,
               code_updated, locked_out
    );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_controller
// Description : Debounced BCD keypad entry with 4-digit code check, code
//               change while open, and optional lockout after repeated
//               mismatches. Optional feature macro: KEYPAD_LOCKOUT_EN
//               (fail counter + LOCKOUT state); absent = mismatch returns
//               to IDLE and locked_out is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_controller #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          LOCK_CYCLES     = 16,
    parameter int          MAX_FAILS       = 3,
    parameter logic [15:0] RESET_CODE      = 16'h1234
) (
    input wire                       clk,
    input wire                       rst,
    keypad_entry_controller_if.slave kp
);

    localparam logic [3:0] c_DB_TARGET = 4'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
`ifdef KEYPAD_LOCKOUT_EN
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
`else
        ST_OPEN    = 3'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] entry_buf_q, entry_buf_d;
    logic [2:0]  digit_count_q, digit_count_d;
    logic [15:0] code_q, code_d;
    logic        press_ack_q, press_ack_d;
    logic        error_q, error_d;
    logic        code_updated_q, code_updated_d;
    logic        mode_q;

    // Debouncer state: run length of identical valid digit, and the re-arm
    // flag that is only set again once the key has been seen released.
    logic [3:0]  db_cnt_q, db_cnt_d;
    logic [3:0]  db_digit_q, db_digit_d;
    logic        armed_q, armed_d;
    logic        w_accept;

`ifdef KEYPAD_LOCKOUT_EN
    localparam int c_FW = $clog2(MAX_FAILS + 1);
    localparam int c_LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FAIL_LIMIT = c_FW'(MAX_FAILS);
    localparam logic [c_LW-1:0] c_LOCK_LAST  = c_LW'(LOCK_CYCLES - 1);

    logic [c_FW-1:0] fail_q, fail_d;
    logic [c_LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [c_FW-1:0] w_fail_inc;

    assign w_fail_inc = fail_q + c_FW'(1);
`else
    // Lockout parameters have no function in this build.
    localparam int c_unused_lockout_cfg = MAX_FAILS + LOCK_CYCLES;
`endif

    // A press is accepted once the run reaches the target while armed.
    assign w_accept = armed_q && (db_cnt_q == c_DB_TARGET);

    // Debounce next state: count identical valid samples, restart on digit
    // change, reject non-BCD codes, re-arm on release.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_digit_d = db_digit_q;
        armed_d    = armed_q;
        if (!kp.bcd_in[4]) begin
            db_cnt_d = 4'd0;
            armed_d  = 1'b1;
        end else if (kp.bcd_in[3:0] > 4'd9) begin
            db_cnt_d = 4'd0;
        end else if ((db_cnt_q == 4'd0) || (db_digit_q != kp.bcd_in[3:0])) begin
            db_cnt_d   = 4'd1;
            db_digit_d = kp.bcd_in[3:0];
        end else if (db_cnt_q != c_DB_TARGET) begin
            db_cnt_d = db_cnt_q + 4'd1;
        end
        if (w_accept && kp.bcd_in[4]) begin
            armed_d = 1'b0;
        end
    end

    // Debounce registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= 4'd0;
            db_digit_q <= 4'd0;
            armed_q    <= 1'b1;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_digit_q <= db_digit_d;
            armed_q    <= armed_d;
        end
    end

    // Controller next state and registered pulse outputs.
    always_comb begin
        state_d        = state_q;
        entry_buf_d    = entry_buf_q;
        digit_count_d  = digit_count_q;
        code_d         = code_q;
        press_ack_d    = 1'b0;
        error_d        = 1'b0;
        code_updated_d = 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
        fail_d         = fail_q;
        lock_cnt_d     = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    press_ack_d   = 1'b1;
                    entry_buf_d   = {12'h000, db_digit_q};
                    digit_count_d = 3'd1;
                    state_d       = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // clear has priority; a coincident press is dropped
                if (kp.clear) begin
                    entry_buf_d   = 16'h0000;
                    digit_count_d = 3'd0;
                    state_d       = ST_IDLE;
                end else if (w_accept) begin
                    press_ack_d   = 1'b1;
                    entry_buf_d   = {entry_buf_q[11:0], db_digit_q};
                    digit_count_d = digit_count_q + 3'd1;
                    if (digit_count_q == 3'd3) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                entry_buf_d   = 16'h0000;
                digit_count_d = 3'd0;
                if (entry_buf_q == code_q) begin
                    state_d = ST_OPEN;
`ifdef KEYPAD_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    error_d = 1'b1;
`ifdef KEYPAD_LOCKOUT_EN
                    fail_d  = w_fail_inc;
                    if (w_fail_inc == c_FAIL_LIMIT) begin
                        state_d    = ST_LOCKOUT;
                        lock_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_OPEN: begin
                if (kp.clear) begin
                    entry_buf_d   = 16'h0000;
                    digit_count_d = 3'd0;
                    state_d       = ST_IDLE;
                end else begin
                    // switching mode abandons any partial new code
                    if (kp.mode != mode_q) begin
                        entry_buf_d   = 16'h0000;
                        digit_count_d = 3'd0;
                    end
                    if (w_accept) begin
                        press_ack_d = 1'b1;
                        if (kp.mode) begin
                            if (digit_count_d == 3'd3) begin
                                code_d         = {entry_buf_d[11:0], db_digit_q};
                                code_updated_d = 1'b1;
                                entry_buf_d    = 16'h0000;
                                digit_count_d  = 3'd0;
                            end else begin
                                entry_buf_d   = {entry_buf_d[11:0], db_digit_q};
                                digit_count_d = digit_count_d + 3'd1;
                            end
                        end
                    end
                end
            end
`ifdef KEYPAD_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_cnt_q == c_LOCK_LAST) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + c_LW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset restores the factory code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            entry_buf_q    <= 16'h0000;
            digit_count_q  <= 3'd0;
            code_q         <= RESET_CODE;
            press_ack_q    <= 1'b0;
            error_q        <= 1'b0;
            code_updated_q <= 1'b0;
            mode_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            entry_buf_q    <= entry_buf_d;
            digit_count_q  <= digit_count_d;
            code_q         <= code_d;
            press_ack_q    <= press_ack_d;
            error_q        <= error_d;
            code_updated_q <= code_updated_d;
            mode_q         <= kp.mode;
        end
    end

`ifdef KEYPAD_LOCKOUT_EN
    // Consecutive-mismatch counter and lockout timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q     <= '0;
            lock_cnt_q <= '0;
        end else begin
            fail_q     <= fail_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
    assign kp.locked_out = (state_q == ST_LOCKOUT);
`else
    assign kp.locked_out = 1'b0;
`endif

    assign kp.press_ack    = press_ack_q;
    assign kp.entry_buf    = entry_buf_q;
    assign kp.digit_count  = digit_count_q;
    assign kp.unlocked     = (state_q == ST_OPEN);
    assign kp.error        = error_q;
    assign kp.code_updated = code_updated_q;

endmodule
`default_nettype wire

// File: doc/keypad_entry_controller.md
KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable valid samples needed to accept a press (range 1..15).
REQ-002 SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clock cycles.
REQ-003 SHALL have parameter MAX_FAILS, default 3: consecutive mismatches that trigger lockout.
REQ-004 SHALL have parameter RESET_CODE, default 16'h1234: stored code after reset, 4 BCD digits, first-entered digit in [15:12].
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 bcd_in  input  5  encoded keypad input: [4] valid, [3:0] digit 0-9.
REQ-008 mode  input  1  0 = enter code, 1 = set new code (honoured only in OPEN).
REQ-009 clear  input  1  discard entry or relock.
REQ-010 press_ack  output  1  one-cycle pulse per accepted press (memory-clocking strobe).
REQ-011 entry_buf  output  16  digits entered so far, shifted left, newest in [3:0].
REQ-012 digit_count  output  3  digits in entry_buf, 0..4.
REQ-013 unlocked  output  1  high while state is OPEN.
REQ-014 error  output  1  one-cycle pulse on code mismatch.
REQ-015 code_updated  output  1  one-cycle pulse when stored code is replaced.
REQ-016 locked_out  output  1  high while state is LOCKOUT.

Function
REQ-017 Press acceptance: bcd_in[4]=1 with the same [3:0] (<=9) for DEBOUNCE_CYCLES consecutive samples -> press_ack on the next cycle; digit change restarts the count; [3:0]>9 never accepted.
REQ-018 Re-arm: after acceptance no further press until bcd_in[4] sampled 0 for at least 1 cycle; holding a key yields exactly one press.
REQ-019 States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT; state changes only on clk edge.
REQ-020 IDLE: accepted press -> ENTRY, digit loaded, digit_count=1; mode ignored.
REQ-021 ENTRY: each press shifts entry_buf left 4 bits, increments digit_count; 4th press -> CHECK.
REQ-022 CHECK (exactly 1 cycle): entry_buf == stored code -> OPEN, fail count cleared; else error pulse, fail count +1, -> LOCKOUT if count reaches MAX_FAILS, otherwise IDLE; entry_buf and digit_count cleared on exit.
REQ-023 unlocked rises the cycle after CHECK; error pulses in the cycle after CHECK.
REQ-024 OPEN, mode=1: presses fill entry_buf; 4th press copies entry_buf to stored code, code_updated pulses next cycle, buffer cleared, stays OPEN.
REQ-025 OPEN, mode=0: presses produce press_ack but no buffer change; mode change mid-entry clears buffer.
REQ-026 clear: ENTRY -> IDLE with buffer cleared; OPEN -> IDLE (relock); ignored in IDLE, CHECK, LOCKOUT.
REQ-027 clear and accepted press in same cycle: clear wins, press dropped (no press_ack).
REQ-028 LOCKOUT: presses ignored (no press_ack) for LOCK_CYCLES cycles, then -> IDLE with fail count cleared.

Reset
REQ-029 rst asserted: state IDLE, stored code=RESET_CODE, entry_buf=0, digit_count=0, fail count=0, debounce cleared, all outputs 0, immediately without clk.
REQ-030 Reset mid-entry or mid-lockout discards all progress; an updated code is lost.

Configuration
REQ-031 Macro KEYPAD_LOCKOUT_EN defined: fail counter and LOCKOUT implemented per REQ-022/028.
REQ-032 Macro absent: no fail counter or LOCKOUT state; mismatch -> IDLE with error pulse; locked_out tied 0; MAX_FAILS/LOCK_CYCLES unused.

Verification
REQ-033 Reset then press 1,2,3,4 (each held 6 cycles, released 2) -> 4 press_ack pulses, digit_count 1..4, unlocked=1 the cycle after CHECK.
REQ-034 Hold digit 7 valid 20 cycles -> exactly one press_ack, acceptance DEBOUNCE_CYCLES+1 cycles after first valid sample; digit 5 held 2 cycles then 7 -> only 7 accepted.
REQ-035 From OPEN, mode=1, enter 9,8,7,6 -> code_updated pulse; clear; enter 9,8,7,6 -> unlocked; enter 1,2,3,4 -> error.
REQ-036 With KEYPAD_LOCKOUT_EN: three wrong codes 0,0,0,0 -> locked_out=1 for 16 cycles, presses ignored, then IDLE; without macro -> three error pulses, locked_out stays 0.
REQ-037 Press 1,2 then clear coincident with 3rd acceptance -> no press_ack, digit_count=0, IDLE; rst mid-entry -> all outputs 0 asynchronously.
